// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period defaults and frame lengths
// used by both the transmit and receive paths and their benches.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int BAUD_END_SYN    = 433;  // 115200 baud at 50 MHz
  localparam int BAUD_END_SIM    = 28;
  localparam int BIT_END_DEFAULT = 8;

  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

  function automatic int frame_cycles(input int baud_end, input bit parity_en);
    return (parity_en ? FRAME_BITS_8E1 : FRAME_BITS_8N1) * (baud_end + 1);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Enable-gated bit-period counter 0..BAUD_END; bit_tick marks the last cycle of each bit.
// Shared by the transmit and receive paths.
module uart_baud_gen #(
  parameter int BAUD_END = 433
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (BAUD_END > 0) ? $clog2(BAUD_END + 1) : 1;

  logic [CW-1:0] cnt_reg;

  assign bit_tick = en && (cnt_reg == CW'(BAUD_END));

  // Held at zero while disabled so the first enabled cycle starts a full bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!en || bit_tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first with a registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx #(
  parameter int BAUD_END = uart_pkg::BAUD_END_SYN,
  parameter int BIT_END  = uart_pkg::BIT_END_DEFAULT
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_trig,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       rs232_tx
);

  import uart_pkg::*;

  uart_state_t state_reg, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic        line_reg, line_next;
  logic        done_reg, done_next;
  logic        bit_tick;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        parity_reg, parity_next;
`endif

  uart_baud_gen #(
    .BAUD_END(BAUD_END)
  ) u_baud (
    .clk      (sclk),
    .rst      (s_rst),
    .en       (state_reg != IDLE),
    .bit_tick (bit_tick)
  );

  assign tx_ready = (state_reg == IDLE);
  assign accept   = tx_trig && tx_ready;
  assign tx_done  = done_reg;
  assign rs232_tx = line_reg;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shift_next = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_next = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_reg == 4'(BIT_END - 1)) begin
            bit_cnt_next = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            shift_next   = shift_reg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is computed from the next state so the pin toggles exactly on bit boundaries.
  always_comb begin
    line_next = 1'b1;
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_next = parity_next;
`endif
      default: line_next = 1'b1;
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_reg   <= IDLE;
      shift_reg   <= 8'd0;
      bit_cnt_reg <= 4'd0;
      line_reg    <= 1'b1;
      done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      line_reg    <= line_next;
      done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

endmodule
